// File: rtl/power_meter_pkg.sv
// power_meter_pkg: shared state type, default colours and bar geometry helper for power_meter
package power_meter_pkg;
   typedef enum logic [1:0] {PM_IDLE, PM_CHARGE, PM_HOLD} pm_state_t;
   localparam logic [11:0] PM_FILL_RGB = 12'hF00;
   localparam logic [11:0] PM_BORDER_RGB = 12'h00F;
   localparam int PM_CW = 12;
   function automatic logic pm_in_span(input logic [PM_CW-1:0] v, input logic [PM_CW-1:0] lo, input logic [PM_CW-1:0] len);
      return v >= lo && v < lo + len;
   endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing and colour bundle passed between overlay stages
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic hsync;
   logic vsync;
   logic hblnk;
   logic vblnk;
   logic [11:0] rgb;
   modport vga_in(input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport vga_out(output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/power_meter_ctrl.sv
// power_meter_ctrl: charge FSM, step/level/hold counters and force latch; POWER_METER_PINGPONG_EN makes the level bounce
module power_meter_ctrl
   import power_meter_pkg::*;
#(
   parameter int MAX_LEVEL = 122,
   parameter int STEP_INTERVAL = 1_234_177,
   parameter int HOLD_FRAMES = 30,
   parameter int FORCE_W = $clog2(MAX_LEVEL + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic charge_btn,
   input  logic arm,
   input  logic vblnk,
   output logic [FORCE_W-1:0] level,
   output logic [FORCE_W-1:0] force_level,
   output logic force_valid,
   output logic meter_busy
);
   localparam int TW = STEP_INTERVAL > 1 ? $clog2(STEP_INTERVAL) : 1;
   localparam int HW = HOLD_FRAMES > 0 ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam logic [FORCE_W-1:0] LMAX = FORCE_W'(MAX_LEVEL);
   pm_state_t state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [FORCE_W-1:0] level_q, level_d, force_q, force_d, level_step;
   logic [HW-1:0] hold_q, hold_d;
   logic valid_q, valid_d, busy_q, busy_d, btn_prev_q, vblnk_prev_q;
   logic press, rel, wrap, rise;
`ifdef POWER_METER_PINGPONG_EN
   logic up_q, up_d, up_step;
`endif

   // level after one step: bounce between 0 and MAX_LEVEL, or saturate at MAX_LEVEL
   always_comb begin
`ifdef POWER_METER_PINGPONG_EN
      up_step = up_q;
      level_step = up_q ? level_q + 1'b1 : level_q - 1'b1;
      if (up_q && level_q == LMAX) begin
         level_step = LMAX - 1'b1;
         up_step = 1'b0;
      end else if (!up_q && level_q == '0) begin
         level_step = FORCE_W'(1);
         up_step = 1'b1;
      end
`else
      level_step = level_q == LMAX ? level_q : level_q + 1'b1;
`endif
   end

   // FSM next state, counters and force latch; release beats abort
   always_comb begin
      press = charge_btn & ~btn_prev_q;
      rel = ~charge_btn & btn_prev_q;
      wrap = tick_q == TW'(STEP_INTERVAL - 1);
      rise = vblnk & ~vblnk_prev_q;
      state_d = state_q;
      tick_d = tick_q;
      level_d = level_q;
      force_d = force_q;
      hold_d = hold_q;
      valid_d = 1'b0;
`ifdef POWER_METER_PINGPONG_EN
      up_d = up_q;
`endif
      case (state_q)
         PM_IDLE: begin
            level_d = '0;
            if (press && arm) begin
               state_d = PM_CHARGE;
               tick_d = '0;
`ifdef POWER_METER_PINGPONG_EN
               up_d = 1'b1;
`endif
            end
         end
         PM_CHARGE: begin
            if (rel) begin
               state_d = PM_HOLD;
               force_d = level_q;
               valid_d = 1'b1;
               hold_d = '0;
            end else if (!arm) begin
               state_d = PM_IDLE;
               level_d = '0;
            end else begin
               tick_d = wrap ? '0 : tick_q + 1'b1;
               level_d = wrap ? level_step : level_q;
`ifdef POWER_METER_PINGPONG_EN
               up_d = wrap ? up_step : up_q;
`endif
            end
         end
         PM_HOLD: begin
            hold_d = rise ? hold_q + 1'b1 : hold_q;
            if (hold_d >= HW'(HOLD_FRAMES)) state_d = PM_IDLE;
         end
         default: state_d = PM_IDLE;
      endcase
      busy_d = state_d != PM_IDLE;
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PM_IDLE;
         tick_q <= '0;
         level_q <= '0;
         force_q <= '0;
         hold_q <= '0;
         valid_q <= 1'b0;
         busy_q <= 1'b0;
         btn_prev_q <= 1'b0;
         vblnk_prev_q <= 1'b0;
`ifdef POWER_METER_PINGPONG_EN
         up_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         tick_q <= tick_d;
         level_q <= level_d;
         force_q <= force_d;
         hold_q <= hold_d;
         valid_q <= valid_d;
         busy_q <= busy_d;
         btn_prev_q <= charge_btn;
         vblnk_prev_q <= vblnk;
`ifdef POWER_METER_PINGPONG_EN
         up_q <= up_d;
`endif
      end
   end

   assign level = level_q;
   assign force_level = force_q;
   assign force_valid = valid_q;
   assign meter_busy = busy_q;
endmodule

// File: rtl/power_meter.sv
// power_meter: charge-and-release force gauge drawn as a bordered bar on the VGA stream; POWER_METER_PINGPONG_EN selects a bouncing level
module power_meter
   import power_meter_pkg::*;
#(
   parameter int X_START = 876,
   parameter int Y_START = 400,
   parameter int BAR_W = 128,
   parameter int BAR_H = 21,
   parameter int BORDER = 3,
   parameter int MAX_LEVEL = 122,
   parameter int STEP_INTERVAL = 1_234_177,
   parameter int HOLD_FRAMES = 30,
   parameter logic [11:0] FILL_RGB = PM_FILL_RGB,
   parameter logic [11:0] BORDER_RGB = PM_BORDER_RGB,
   parameter int FORCE_W = $clog2(MAX_LEVEL + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic charge_btn,
   input  logic arm,
   output logic [FORCE_W-1:0] force_level,
   output logic force_valid,
   output logic meter_busy,
   vga_if.vga_in vga_in,
   vga_if.vga_out vga_out
);
   localparam logic [PM_CW-1:0] XS = PM_CW'(X_START);
   localparam logic [PM_CW-1:0] YS = PM_CW'(Y_START);
   localparam logic [PM_CW-1:0] BW = PM_CW'(BAR_W);
   localparam logic [PM_CW-1:0] BH = PM_CW'(BAR_H);
   localparam logic [PM_CW-1:0] XI = PM_CW'(X_START + BORDER);
   localparam logic [PM_CW-1:0] YI = PM_CW'(Y_START + BORDER);
   localparam logic [PM_CW-1:0] IW = PM_CW'(BAR_W - 2 * BORDER);
   localparam logic [PM_CW-1:0] IH = PM_CW'(BAR_H - 2 * BORDER);
   logic [FORCE_W-1:0] level;
   logic [PM_CW-1:0] h, v;
   logic frame, border, fill;
   logic [11:0] rgb_d, rgb_q;
   logic [10:0] hcount_q, vcount_q;
   logic hsync_q, vsync_q, hblnk_q, vblnk_q;

   power_meter_ctrl #(
      .MAX_LEVEL(MAX_LEVEL),
      .STEP_INTERVAL(STEP_INTERVAL),
      .HOLD_FRAMES(HOLD_FRAMES),
      .FORCE_W(FORCE_W)
   ) u_ctrl (
      .clk(clk),
      .rst(rst),
      .charge_btn(charge_btn),
      .arm(arm),
      .vblnk(vga_in.vblnk),
      .level(level),
      .force_level(force_level),
      .force_valid(force_valid),
      .meter_busy(meter_busy)
   );

   // bar overlay: fill over border over the incoming pixel, only while charging or holding
   always_comb begin
      h = PM_CW'(vga_in.hcount);
      v = PM_CW'(vga_in.vcount);
      frame = pm_in_span(h, XS, BW) && pm_in_span(v, YS, BH);
      border = frame && !(pm_in_span(h, XI, IW) && pm_in_span(v, YI, IH));
      fill = frame && !border && (h - XI) < PM_CW'(level);
      rgb_d = !meter_busy ? vga_in.rgb : fill ? FILL_RGB : border ? BORDER_RGB : vga_in.rgb;
   end

   // one-cycle aligned VGA register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         hblnk_q <= 1'b0;
         vblnk_q <= 1'b0;
         rgb_q <= '0;
      end else begin
         hcount_q <= vga_in.hcount;
         vcount_q <= vga_in.vcount;
         hsync_q <= vga_in.hsync;
         vsync_q <= vga_in.vsync;
         hblnk_q <= vga_in.hblnk;
         vblnk_q <= vga_in.vblnk;
         rgb_q <= rgb_d;
      end
   end

   assign vga_out.hcount = hcount_q;
   assign vga_out.vcount = vcount_q;
   assign vga_out.hsync = hsync_q;
   assign vga_out.vsync = vsync_q;
   assign vga_out.hblnk = hblnk_q;
   assign vga_out.vblnk = vblnk_q;
   assign vga_out.rgb = rgb_q;
endmodule

// File: tb/tb_power_meter.sv
// tb_power_meter: directed checks of charge, release, abort, hold timeout, drawing and reset
module tb_power_meter;
   localparam int X = 876;
   localparam int Y = 400;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic charge_btn = 1'b0;
   logic arm = 1'b1;
   logic [3:0] force_level;
   logic force_valid;
   logic meter_busy;
   int n = 0;
   int bad = 0;
   vga_if vi();
   vga_if vo();

   power_meter #(.STEP_INTERVAL(4), .MAX_LEVEL(10), .HOLD_FRAMES(2)) dut (
      .clk(clk),
      .rst(rst),
      .charge_btn(charge_btn),
      .arm(arm),
      .force_level(force_level),
      .force_valid(force_valid),
      .meter_busy(meter_busy),
      .vga_in(vi),
      .vga_out(vo)
   );

   always #5 clk = ~clk;

   task automatic tick(input int k = 1);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic frames(input int k);
      repeat (k) begin
         vi.vblnk = 1'b1;
         tick();
         vi.vblnk = 1'b0;
         tick();
      end
   endtask

   initial begin
      vi.hcount = 11'd5;
      vi.vcount = 11'd7;
      vi.hsync = 1'b1;
      vi.vsync = 1'b1;
      vi.hblnk = 1'b0;
      vi.vblnk = 1'b0;
      vi.rgb = 12'hABC;
      tick(2);
      chk("rst_force", 32'(force_level), 32'd0);
      chk("rst_valid", 32'(force_valid), 32'd0);
      chk("rst_busy", 32'(meter_busy), 32'd0);
      chk("rst_rgb", 32'(vo.rgb), 32'd0);
      chk("rst_hcount", 32'(vo.hcount), 32'd0);
      chk("rst_hsync", 32'(vo.hsync), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_pass_rgb", 32'(vo.rgb), 32'hABC);
      // press at edge 0, release sampled at edge 18 -> 4 steps
      charge_btn = 1'b1;
      tick();
      chk("charge_busy", 32'(meter_busy), 32'd1);
      tick(17);
      chk("no_early_valid", 32'(force_valid), 32'd0);
      charge_btn = 1'b0;
      tick();
      chk("rel1_force", 32'(force_level), 32'd4);
      chk("rel1_valid", 32'(force_valid), 32'd1);
      chk("rel1_busy", 32'(meter_busy), 32'd1);
      tick();
      chk("rel1_valid_drop", 32'(force_valid), 32'd0);
      frames(1);
      chk("hold_busy", 32'(meter_busy), 32'd1);
      vi.vblnk = 1'b1;
      tick();
      chk("hold_done_busy", 32'(meter_busy), 32'd0);
      vi.vblnk = 1'b0;
      tick();
      // long hold: 24 steps
      charge_btn = 1'b1;
      tick(100);
      charge_btn = 1'b0;
      tick();
`ifdef POWER_METER_PINGPONG_EN
      chk("rel2_force", 32'(force_level), 32'd4);
`else
      chk("rel2_force", 32'(force_level), 32'd10);
`endif
      chk("rel2_valid", 32'(force_valid), 32'd1);
      frames(2);
      chk("rel2_idle", 32'(meter_busy), 32'd0);
      // press without arm, border pixel must pass through
      arm = 1'b0;
      vi.hcount = 11'(X + 1);
      vi.vcount = 11'(Y + 10);
      vi.rgb = 12'h123;
      charge_btn = 1'b1;
      tick();
      chk("noarm_busy", 32'(meter_busy), 32'd0);
      chk("noarm_valid", 32'(force_valid), 32'd0);
      tick();
      chk("noarm_rgb", 32'(vo.rgb), 32'h123);
      charge_btn = 1'b0;
      tick();
      // abort at level 3
      arm = 1'b1;
      charge_btn = 1'b1;
      tick(13);
      chk("abort_pre_busy", 32'(meter_busy), 32'd1);
      arm = 1'b0;
      tick();
      chk("abort_busy", 32'(meter_busy), 32'd0);
      chk("abort_valid", 32'(force_valid), 32'd0);
`ifdef POWER_METER_PINGPONG_EN
      chk("abort_force", 32'(force_level), 32'd4);
`else
      chk("abort_force", 32'(force_level), 32'd10);
`endif
      charge_btn = 1'b0;
      tick();
      chk("abort_rel_valid", 32'(force_valid), 32'd0);
      // draw at level 5 (edges 20..23)
      arm = 1'b1;
      charge_btn = 1'b1;
      tick(21);
      vi.hcount = 11'(X + 7);
      vi.vcount = 11'(Y + 10);
      vi.rgb = 12'h5A5;
      vi.hsync = 1'b1;
      vi.vsync = 1'b0;
      vi.hblnk = 1'b1;
      tick();
      chk("fill_rgb", 32'(vo.rgb), 32'hF00);
      chk("fill_hcount", 32'(vo.hcount), 32'(X + 7));
      chk("fill_vcount", 32'(vo.vcount), 32'(Y + 10));
      chk("fill_hsync", 32'(vo.hsync), 32'd1);
      chk("fill_vsync", 32'(vo.vsync), 32'd0);
      chk("fill_hblnk", 32'(vo.hblnk), 32'd1);
      vi.hcount = 11'(X + 8);
      tick();
      chk("beyond_fill_rgb", 32'(vo.rgb), 32'h5A5);
      vi.hcount = 11'(X + 1);
      vi.hblnk = 1'b0;
      tick();
      chk("border_rgb", 32'(vo.rgb), 32'h00F);
      chk("border_hblnk", 32'(vo.hblnk), 32'd0);
      // release and arm fall together at edge 24
      charge_btn = 1'b0;
      arm = 1'b0;
      tick();
      chk("relabort_valid", 32'(force_valid), 32'd1);
      chk("relabort_force", 32'(force_level), 32'd5);
      chk("relabort_busy", 32'(meter_busy), 32'd1);
      arm = 1'b1;
      tick();
      chk("hold_border_rgb", 32'(vo.rgb), 32'h00F);
      charge_btn = 1'b1;
      tick();
      chk("hold_press_valid", 32'(force_valid), 32'd0);
      charge_btn = 1'b0;
      tick();
      chk("hold_rel_valid", 32'(force_valid), 32'd0);
      chk("hold_rel_force", 32'(force_level), 32'd5);
      frames(2);
      chk("hold2_idle", 32'(meter_busy), 32'd0);
      tick();
      chk("idle_border_pass", 32'(vo.rgb), 32'h5A5);
      // reset mid-charge, with a release on the same edge
      charge_btn = 1'b1;
      tick(11);
      rst = 1'b1;
      charge_btn = 1'b0;
      tick();
      chk("midrst_valid", 32'(force_valid), 32'd0);
      chk("midrst_busy", 32'(meter_busy), 32'd0);
      chk("midrst_force", 32'(force_level), 32'd0);
      chk("midrst_rgb", 32'(vo.rgb), 32'd0);
      chk("midrst_hcount", 32'(vo.hcount), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_valid", 32'(force_valid), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n, bad);
      $finish;
   end
endmodule
